// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2 stride-2 signed max-pool; optional fused ReLU via MAXPOOL_RELU_EN
module maxpool2x2_stream #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LN = IMG_W / 2;
    localparam int LW = (LN > 1) ? $clog2(LN) : 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] linebuf [LN];

    logic [DATA_W-1:0] pix;
    logic [DATA_W-1:0] pair_max;
    logic [DATA_W-1:0] lb_rd;
    logic [DATA_W-1:0] win_max;
    logic [LW-1:0]     lb_idx;
    logic              col_last;
    logic              row_last;

    always_comb begin
`ifdef MAXPOOL_RELU_EN
        pix = in_data[DATA_W-1] ? '0 : in_data;
`else
        pix = in_data;
`endif
        pair_max = ($signed(pix) > $signed(held)) ? pix : held;
        lb_idx   = LW'(col >> 1);
        lb_rd    = linebuf[lb_idx];
        win_max  = ($signed(pair_max) > $signed(lb_rd)) ? pair_max : lb_rd;
        col_last = (col == CW'(IMG_W - 1));
        row_last = (row == RW'(IMG_H - 1));
    end

    // Even rows only deposit horizontal pair maxima; odd rows consume them.
    always_ff @(posedge clk) begin
        if (in_valid && col[0] && !row[0]) begin
            linebuf[lb_idx] <= pair_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            held       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                if (!col[0]) begin
                    held <= pix;
                end else if (row[0]) begin
                    out_valid  <= 1'b1;
                    out_data   <= win_max;
                    frame_done <= col_last && row_last;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - scoreboard bench for maxpool2x2_stream (4x2 and 8x8 instances)
module tb_maxpool2x2_stream;

    typedef struct {
        logic [15:0] d;
        logic        fd;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   fd_cnt_a = 0;
    int   fd_cnt_b = 0;

    logic        a_rst, a_iv, a_ov, a_fd;
    logic [15:0] a_id, a_od;
    logic        b_rst, b_iv, b_ov, b_fd;
    logic [15:0] b_id, b_od;

    exp_t qa[$];
    exp_t qb[$];
    logic [15:0] fa [8];

    maxpool2x2_stream #(.IMG_W(4), .IMG_H(2), .DATA_W(16)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_iv), .in_data(a_id),
        .out_valid(a_ov), .out_data(a_od), .frame_done(a_fd)
    );

    maxpool2x2_stream #(.IMG_W(8), .IMG_H(8), .DATA_W(16)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_iv), .in_data(b_id),
        .out_valid(b_ov), .out_data(b_od), .frame_done(b_fd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per output pulse, check value, frame flag and arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (a_ov === 1'b1) begin
            if (a_fd === 1'b1) fd_cnt_a++;
            if (qa.size() == 0) begin
                chk("a_unexpected_output", 32'(a_od), 32'hdead_0000);
            end else begin
                e = qa.pop_front();
                chk("a_data", 32'(a_od), 32'(e.d));
                chk("a_frame_done", 32'(a_fd), 32'(e.fd));
                chk("a_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (!a_rst) begin
            chk("a_idle_frame_done", 32'(a_fd), 32'h0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_ov === 1'b1) begin
            if (b_fd === 1'b1) fd_cnt_b++;
            if (qb.size() == 0) begin
                chk("b_unexpected_output", 32'(b_od), 32'hdead_0000);
            end else begin
                e = qb.pop_front();
                chk("b_data", 32'(b_od), 32'(e.d));
                chk("b_frame_done", 32'(b_fd), 32'(e.fd));
                chk("b_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (!b_rst) begin
            chk("b_idle_frame_done", 32'(b_fd), 32'h0);
        end
    end

    // Drives fa[] as one 4x2 frame; pixels 5 and 7 complete the two windows.
    task automatic frame_a(input logic [15:0] e0, input logic [15:0] e1, input int gap);
        for (int k = 0; k < 8; k++) begin
            a_iv = 1'b1;
            a_id = fa[k];
            if (k == 5) qa.push_back('{e0, 1'b0, cyc + 1});
            if (k == 7) qa.push_back('{e1, 1'b1, cyc + 1});
            @(negedge clk);
            a_iv = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic frame_b();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                b_iv = 1'b1;
                b_id = 16'(r * 16 + c);
                if ((r % 2 == 1) && (c % 2 == 1))
                    qb.push_back('{16'((2 * (r / 2) + 1) * 16 + (2 * (c / 2) + 1)),
                                   (r == 7 && c == 7), cyc + 1});
                @(negedge clk);
                b_iv = 1'b0;
            end
        end
    endtask

    initial begin
        logic [15:0] exp_neg;
        logic [15:0] exp_min;
        a_rst = 1'b1; a_iv = 1'b0; a_id = '0;
        b_rst = 1'b1; b_iv = 1'b0; b_id = '0;
        repeat (3) @(negedge clk);
        chk("a_reset_valid", 32'(a_ov), 32'h0);
        chk("a_reset_data", 32'(a_od), 32'h0);
        chk("a_reset_frame_done", 32'(a_fd), 32'h0);
        chk("b_reset_valid", 32'(b_ov), 32'h0);
        chk("b_reset_data", 32'(b_od), 32'h0);
        chk("b_reset_frame_done", 32'(b_fd), 32'h0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);

`ifdef MAXPOOL_RELU_EN
        exp_neg = 16'h0000;
        exp_min = 16'h0000;
`else
        exp_neg = 16'hFFFF;
        exp_min = 16'h8000;
`endif

        fa = '{16'h0700, 16'h0230, 16'h1420, 16'hA648,
               16'h8000, 16'h7FFF, 16'h1997, 16'hE822};
        frame_a(16'h7FFF, 16'h1997, 0);

        fa = '{16'h0100, 16'h0100, 16'hA648, 16'h8000,
               16'h0100, 16'h0100, 16'hE822, 16'hFFFF};
        frame_a(16'h0100, exp_neg, 0);

        fa = '{16'h0700, 16'h0230, 16'h1420, 16'hA648,
               16'h8000, 16'h7FFF, 16'h1997, 16'hE822};
        frame_a(16'h7FFF, 16'h1997, 3);

        fa = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF,
               16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF};
        frame_a(exp_min, 16'h7FFF, 0);

        frame_b();
        frame_b();

        // Abort: reset lands on the same edge as pixel (1,1), so its window must be dropped.
        for (int k = 0; k < 9; k++) begin
            b_iv = 1'b1;
            b_id = 16'(k < 8 ? k : 16);
            @(negedge clk);
        end
        b_rst = 1'b1;
        b_id  = 16'h0011;
        @(negedge clk);
        chk("b_abort_valid", 32'(b_ov), 32'h0);
        chk("b_abort_data", 32'(b_od), 32'h0);
        chk("b_abort_frame_done", 32'(b_fd), 32'h0);
        b_rst = 1'b0;
        b_iv  = 1'b0;
        @(negedge clk);
        frame_b();

        for (int t = 0; t < 20 && (qa.size() != 0 || qb.size() != 0); t++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("a_queue_drained", 32'(qa.size()), 32'h0);
        chk("b_queue_drained", 32'(qb.size()), 32'h0);
        chk("a_frame_done_count", 32'(fd_cnt_a), 32'd4);
        chk("b_frame_done_count", 32'(fd_cnt_b), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_stream.md
# maxpool2x2_stream

Streaming 2×2, stride-2 max-pooling stage that consumes the raster-ordered 16-bit signed fixed-point activations leaving the ReLU stage and emits one pooled value per 2×2 window to the next convolution layer's input buffer. It holds one half-width line buffer of horizontal pair maxima, so a full feature map is pooled in a single pass with no frame storage.

## Interface
Parameters:
- IMG_W, 8, feature-map width in pixels; even, ≥2
- IMG_H, 8, feature-map height in rows; even, ≥2
- DATA_W, 16, activation width; two's complement, Q8.8

Ports:
- CLK  input  1  clock; all logic on rising edge
- RST  input  1  synchronous, active-high reset
- IN_VALID  input  1  IN_DATA carries a pixel this cycle
- IN_DATA  input  DATA_W  signed pixel, raster order (row-major, column 0 first)
- OUT_VALID  output  1  OUT_DATA holds a pooled result this cycle (1-cycle pulse)
- OUT_DATA  output  DATA_W  signed maximum of one 2×2 window
- FRAME_DONE  output  1  1-cycle pulse with the last window of a frame

## Operation
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1), advance only on IN_VALID. col wraps to 0 and increments row; row wraps to 0 after IMG_H-1. No idle/start state: the first valid pixel after reset is (row 0, col 0).
- Even col: pixel is held in a pair register.
- Odd col: pair max p = max(held, IN_DATA), signed compare.
  - Even row: p written to line buffer entry col>>1.
  - Odd row: window max = max(p, linebuf[col>>1]) registered to OUT_DATA, OUT_VALID=1 next cycle.
- FRAME_DONE asserted together with OUT_VALID for the window containing (IMG_H-1, IMG_W-1).
- Comparison is signed: 0x8000 is the smallest value, 0x7FFF the largest. Ties give the identical value; no rounding, no width growth.
- No backpressure: downstream accepts every OUT_VALID pulse. Gaps in IN_VALID (any length) are permitted anywhere, including mid-pair and between rows; state holds.
- Line buffer is IMG_W/2 entries of DATA_W; contents after reset are don't-care (always written in an even row before read).

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, FRAME_DONE=0, col=0, row=0, pair register=0.
- Latency: OUT_VALID rises in the cycle after the odd-row, odd-column pixel is accepted (1 cycle).
- Throughput: one pixel per cycle; output rate IMG_W/2 results per two input rows.
- Outputs when OUT_VALID=0: OUT_DATA holds its last value; FRAME_DONE=0.
- RST during a frame: counters and outputs return to reset values in the next cycle; a pending output from the same edge is dropped; next valid pixel is (0,0). RST dominates IN_VALID in the same cycle.
- Back-to-back frames: pixel (0,0) of the next frame may arrive the cycle immediately after (IMG_H-1, IMG_W-1); no bubble required.

## Configuration
- MAXPOOL_RELU_EN defined: each input pixel is clamped to 0 when its sign bit is set, before any compare (fused ReLU, allows the separate ReLU stage to be bypassed). A window of all-negative inputs yields 0x0000.
- Not defined: raw signed inputs are pooled; an all-negative window yields its largest (least negative) value.

## Test plan
- IMG_W=4, IMG_H=2; row0 = 0x0700, 0x0230, 0x1420, 0xA648; row1 = 0x8000, 0x7FFF, 0x1997, 0xE822 -> OUT_DATA 0x7FFF then 0x1997, each one cycle after pixels 5 and 7 accepted; FRAME_DONE with 0x1997.
- IMG_W=4, IMG_H=2, window 0xA648, 0x8000 / 0xE822, 0xFFFF -> 0xFFFF without MAXPOOL_RELU_EN, 0x0000 with it.
- Same as first scenario with IN_VALID low for 3 cycles between every pixel -> identical outputs, each still 1 cycle after the triggering pixel.
- Default 8×8, two frames back-to-back with pixel = row*16+col -> 16 outputs per frame, value (2i+1)*16+(2j+1), FRAME_DONE exactly twice.
- RST asserted after row0 plus 2 pixels of row1, then a full clean frame -> no output from the aborted frame; clean frame results correct; outputs 0 during reset.
- Ties: all four window pixels 0x0100 -> 0x0100; 0x8000 vs 0x8000 -> 0x8000 (MAXPOOL_RELU_EN undefined).
